// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : hazard_ctrl
// Description : Hazard and forwarding controller for the 5-stage MIPS pipeline.
//               It keeps shadow copies of dst/Tnew/source fields for the E, M
//               and W stages, and from them it generates stall/flush_e, the
//               D/E/M forwarding mux selects, and the mult/div busy counter.
//               Optional feature: define HAZARD_STALL_CNT_EN to add the 32-bit
//               stall_cnt output, which counts stalled cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] rs_d,
    input  logic [4:0] rt_d,
    input  logic [1:0] tuse_rs_d,
    input  logic [1:0] tuse_rt_d,
    input  logic [4:0] dst_d,
    input  logic [1:0] tnew_d,
    input  logic       is_mult_d,
    input  logic       is_div_d,
    input  logic       uses_md_d,
    output logic       stall,
    output logic       flush_e,
    output logic [1:0] fwd_rs_d,
    output logic [1:0] fwd_rt_d,
    output logic [1:0] fwd_rs_e,
    output logic [1:0] fwd_rt_e,
    output logic [1:0] fwd_rt_m,
    output logic       md_busy
`ifdef HAZARD_STALL_CNT_EN
    ,
    output logic [31:0] stall_cnt
`endif
);

    localparam int C_MAX_CYCLES = (DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES;
    localparam int C_CNT_W      = $clog2(C_MAX_CYCLES + 1);
    localparam logic [C_CNT_W-1:0] C_MULT_LOAD = C_CNT_W'(MULT_CYCLES);
    localparam logic [C_CNT_W-1:0] C_DIV_LOAD  = C_CNT_W'(DIV_CYCLES);
    localparam logic [1:0]         C_TUSE_NONE = 2'd3;

    // E-stage shadow
    logic [4:0]         r_dstE;
    logic [1:0]         r_tnewE;
    logic [4:0]         r_rsE;
    logic [4:0]         r_rtE;
    logic               r_multE;
    logic               r_divE;
    // M-stage shadow
    logic [4:0]         r_dstM;
    logic [1:0]         r_tnewM;
    logic [4:0]         r_rtM;
    // W-stage shadow (Tnew is always 0 here, so only dst is kept)
    logic [4:0]         r_dstW;
    // mult/div busy counter
    logic [C_CNT_W-1:0] r_mdCnt;

    logic               w_stallRs;
    logic               w_stallRt;
    logic               w_stallMd;
    logic               w_mdStartE;
    logic               w_stall;
    logic [1:0]         w_fwdRsD;
    logic [1:0]         w_fwdRtD;
    logic [1:0]         w_fwdRsE;
    logic [1:0]         w_fwdRtE;
    logic [1:0]         w_fwdRtM;

    // Register 0 is hard-wired, so a write to it never produces a dependency.
    function automatic logic regMatch(input logic [4:0] dst, input logic [4:0] src);
        return (dst != 5'd0) && (dst == src);
    endfunction

    // D-stage select: E (PC+8 of jal) > M result > W RegData > GRF.
    function automatic logic [1:0] selD(input logic [4:0] src,
                                        input logic [4:0] dstE, input logic [1:0] tnewE,
                                        input logic [4:0] dstM, input logic [1:0] tnewM,
                                        input logic [4:0] dstW);
        if (regMatch(dstE, src) && (tnewE == 2'd0))
            return 2'b11;
        else if (regMatch(dstM, src) && (tnewM == 2'd0))
            return 2'b01;
        else if (regMatch(dstW, src))
            return 2'b10;
        else
            return 2'b00;
    endfunction

    // E-stage select: M ALUOut > W RegData > pipeline register.
    function automatic logic [1:0] selE(input logic [4:0] src,
                                        input logic [4:0] dstM, input logic [1:0] tnewM,
                                        input logic [4:0] dstW);
        if (regMatch(dstM, src) && (tnewM == 2'd0))
            return 2'b01;
        else if (regMatch(dstW, src))
            return 2'b10;
        else
            return 2'b00;
    endfunction

    // Stall decision: a source needed before its producer can deliver it,
    // or any HI/LO access while the mult/div unit is starting or busy.
    always_comb begin
        w_stallRs  = (tuse_rs_d != C_TUSE_NONE) &&
                     ((regMatch(r_dstE, rs_d) && (tuse_rs_d < r_tnewE)) ||
                      (regMatch(r_dstM, rs_d) && (tuse_rs_d < r_tnewM)));
        w_stallRt  = (tuse_rt_d != C_TUSE_NONE) &&
                     ((regMatch(r_dstE, rt_d) && (tuse_rt_d < r_tnewE)) ||
                      (regMatch(r_dstM, rt_d) && (tuse_rt_d < r_tnewM)));
        w_mdStartE = r_multE | r_divE;
        w_stallMd  = uses_md_d && (w_mdStartE || (r_mdCnt != '0));
        w_stall    = w_stallRs || w_stallRt || w_stallMd;
    end

    // Forwarding selects; a producer still computing (Tnew > 0) never forwards.
    always_comb begin
        w_fwdRsD = selD(rs_d, r_dstE, r_tnewE, r_dstM, r_tnewM, r_dstW);
        w_fwdRtD = selD(rt_d, r_dstE, r_tnewE, r_dstM, r_tnewM, r_dstW);
        w_fwdRsE = selE(r_rsE, r_dstM, r_tnewM, r_dstW);
        w_fwdRtE = selE(r_rtE, r_dstM, r_tnewM, r_dstW);
        w_fwdRtM = regMatch(r_dstW, r_rtM) ? 2'b10 : 2'b00;
    end

    // Shadow pipeline: D enters E unless stalled (bubble), then E->M->W.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_dstE  <= 5'd0;
            r_tnewE <= 2'd0;
            r_rsE   <= 5'd0;
            r_rtE   <= 5'd0;
            r_multE <= 1'b0;
            r_divE  <= 1'b0;
            r_dstM  <= 5'd0;
            r_tnewM <= 2'd0;
            r_rtM   <= 5'd0;
            r_dstW  <= 5'd0;
        end else begin
            if (w_stall) begin
                r_dstE  <= 5'd0;
                r_tnewE <= 2'd0;
                r_rsE   <= 5'd0;
                r_rtE   <= 5'd0;
                r_multE <= 1'b0;
                r_divE  <= 1'b0;
            end else begin
                r_dstE  <= dst_d;
                r_tnewE <= tnew_d;
                r_rsE   <= rs_d;
                r_rtE   <= rt_d;
                r_multE <= is_mult_d;
                r_divE  <= is_div_d;
            end
            r_dstM  <= r_dstE;
            r_tnewM <= (r_tnewE == 2'd0) ? 2'd0 : (r_tnewE - 2'd1);
            r_rtM   <= r_rtE;
            r_dstW  <= r_dstM;
        end
    end

    // Busy counter: loads when a mult/div leaves E, otherwise counts down to 0.
    always_ff @(posedge clk) begin
        if (reset)
            r_mdCnt <= '0;
        else if (r_multE)
            r_mdCnt <= C_MULT_LOAD;
        else if (r_divE)
            r_mdCnt <= C_DIV_LOAD;
        else if (r_mdCnt != '0)
            r_mdCnt <= r_mdCnt - C_CNT_W'(1);
    end

`ifdef HAZARD_STALL_CNT_EN
    logic [31:0] r_stallCnt;

    // Free-running count of stalled cycles; wraps naturally at 2^32.
    always_ff @(posedge clk) begin
        if (reset)
            r_stallCnt <= 32'd0;
        else if (w_stall)
            r_stallCnt <= r_stallCnt + 32'd1;
    end

    assign stall_cnt = r_stallCnt;
`endif

    assign stall    = w_stall;
    assign flush_e  = w_stall;
    assign fwd_rs_d = w_fwdRsD;
    assign fwd_rt_d = w_fwdRtD;
    assign fwd_rs_e = w_fwdRsE;
    assign fwd_rt_e = w_fwdRtE;
    assign fwd_rt_m = w_fwdRtM;
    assign md_busy  = (r_mdCnt != '0);

endmodule
`default_nettype wire
